// File: rtl/hms_time_counter_pkg.sv
// Shared definitions for the iCEstick clock: FSM states, BCD limits,
// system clock rate and load validation.
package hms_time_counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam logic [3:0]  MAX_SEC_TENS      = 4'd5;
    localparam logic [3:0]  MAX_UNITS         = 4'd9;
    localparam int unsigned HOUR_WRAP_DEFAULT = 24;
    localparam int unsigned CLK_HZ            = 12_000_000;

    // True when {hh, mm, ss} is a legal BCD time of day for the given hour mode.
    // Once every units nibble is <= 9, a plain 8-bit compare orders BCD values correctly.
    function automatic logic bcd_time_ok(input logic [7:0] hh,
                                         input logic [7:0] mm,
                                         input logic [7:0] ss,
                                         input int unsigned hour_wrap);
        logic ok;
        ok = (hh[3:0] <= MAX_UNITS) && (mm[3:0] <= MAX_UNITS) && (ss[3:0] <= MAX_UNITS) &&
             (mm[7:4] <= MAX_SEC_TENS) && (ss[7:4] <= MAX_SEC_TENS);
        if (hour_wrap == 12) begin
            ok = ok && (hh >= 8'h01) && (hh <= 8'h12);
        end else begin
            ok = ok && (hh <= 8'h23);
        end
        return ok;
    endfunction

endpackage

// File: rtl/hms_time_counter_bcd.sv
// Two-digit BCD counter running MIN_VALUE..MAX_VALUE with a carry for chaining.
module bcd_mod_counter
    import hms_time_counter_pkg::*;
#(
    parameter logic [7:0] MAX_VALUE   = 8'h59,
    parameter logic [7:0] MIN_VALUE   = 8'h00,
    parameter logic [7:0] RESET_VALUE = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] value,
    output logic       carry_out
);

    logic [7:0] value_q, value_d;

    // Next value: load has priority, otherwise BCD increment with wrap to MIN_VALUE.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (inc) begin
            if (value_q == MAX_VALUE) begin
                value_d = MIN_VALUE;
            end else if (value_q[3:0] == MAX_UNITS) begin
                value_d = {value_q[7:4] + 4'd1, 4'd0};
            end else begin
                value_d = {value_q[7:4], value_q[3:0] + 4'd1};
            end
        end
    end

    // Digit register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_q <= RESET_VALUE;
        end else begin
            value_q <= value_d;
        end
    end

    assign value     = value_q;
    assign carry_out = inc && !load && (value_q == MAX_VALUE);

endmodule

// File: rtl/hms_time_counter.sv
// 24/12-hour BCD time-of-day counter advanced by rising edges of the 1 Hz
// divider output, with a valid/ready port for setting the time.
module hms_time_counter
    import hms_time_counter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOUR_WRAP   = HOUR_WRAP_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_level,
    input  logic       run,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       sec_pulse,
    output logic       load_err
);

    localparam logic [7:0] HH_MAX   = (HOUR_WRAP == 12) ? 8'h12 : 8'h23;
    localparam logic [7:0] HH_MIN   = (HOUR_WRAP == 12) ? 8'h01 : 8'h00;
    localparam logic [7:0] HH_RESET = (HOUR_WRAP == 12) ? 8'h12 : 8'h00;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   edge_q, edge_d;
    state_t                 state_q, state_d;
    logic                   sec_pulse_q, sec_pulse_d;
    logic                   load_err_q, load_err_d;

    logic step, accept, load_ok, do_load, advance;
    logic ss_carry, mm_carry, hh_carry_unused;

    // Synchronizer shift and edge register; these run every cycle so a stale edge never fires later.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], tick_level};
        edge_d = sync_q[SYNC_STAGES-1];
    end

    assign step = sync_q[SYNC_STAGES-1] & ~edge_q;

    // Next state, handshake and strobe generation; a load always beats a coincident step.
    always_comb begin
        state_d     = state_q;
        load_ready  = (state_q != LOAD);
        accept      = load_valid & load_ready;
        load_ok     = bcd_time_ok(load_hh, load_mm, load_ss, HOUR_WRAP);
        do_load     = accept & load_ok;
        advance     = (state_q == COUNT) & run & step & ~accept;
        sec_pulse_d = advance;
        load_err_d  = accept & ~load_ok;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = LOAD;
                end else if (run) begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (accept) begin
                    state_d = LOAD;
                end else if (!run) begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                state_d = run ? COUNT : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q      <= '0;
            edge_q      <= 1'b0;
            state_q     <= IDLE;
            sec_pulse_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            edge_q      <= edge_d;
            state_q     <= state_d;
            sec_pulse_q <= sec_pulse_d;
            load_err_q  <= load_err_d;
        end
    end

    assign sec_pulse = sec_pulse_q;
    assign load_err  = load_err_q;

    bcd_mod_counter #(
        .MAX_VALUE   (8'h59),
        .MIN_VALUE   (8'h00),
        .RESET_VALUE (8'h00)
    ) u_ss (
        .clk       (clk),
        .reset     (reset),
        .inc       (advance),
        .load      (do_load),
        .load_val  (load_ss),
        .value     (ss),
        .carry_out (ss_carry)
    );

    bcd_mod_counter #(
        .MAX_VALUE   (8'h59),
        .MIN_VALUE   (8'h00),
        .RESET_VALUE (8'h00)
    ) u_mm (
        .clk       (clk),
        .reset     (reset),
        .inc       (ss_carry),
        .load      (do_load),
        .load_val  (load_mm),
        .value     (mm),
        .carry_out (mm_carry)
    );

    bcd_mod_counter #(
        .MAX_VALUE   (HH_MAX),
        .MIN_VALUE   (HH_MIN),
        .RESET_VALUE (HH_RESET)
    ) u_hh (
        .clk       (clk),
        .reset     (reset),
        .inc       (mm_carry),
        .load      (do_load),
        .load_val  (load_hh),
        .value     (hh),
        .carry_out (hh_carry_unused)
    );

endmodule
